golden_nonce_collector: RTL and testbench
=========================================

Name: golden_nonce_collector

Overview:
- Sits directly downstream of the target checker in the mining top level.
- Re-associates each `valid` pulse with the nonce that produced it. It does this by delaying the issued nonce stream by the fixed pipeline latency.
- Winning nonces are queued in a small result FIFO and presented to the host/UART side on a ready/valid handshake.
- Keeps saturating found/dropped counters for status readout.

Parameters:
- LATENCY, 200, cycles from a nonce appearing on `nonce_in` to its `valid` result appearing on `hit_in`; must be ≥2.
- FIFO_DEPTH, 4, result FIFO entries; power of two, ≥2.
- CNT_W, 16, width of the found/dropped counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- nonce_in  in  32  nonce issued to the padder this cycle (nonce generator output).
- hit_in  in  1  target checker `valid`; 1 = hash for the nonce issued LATENCY cycles ago is ≤ target.
- res_valid  out  1  result FIFO not empty.
- res_nonce  out  32  oldest queued winning nonce; stable while res_valid=1 and res_ready=0.
- res_ready  in  1  consumer accepts `res_nonce` when res_valid=1 and res_ready=1.
- primed  out  1  1 once LATENCY cycles have elapsed since reset release.
- found_count  out  CNT_W  accepted hits, saturating.
- drop_count  out  CNT_W  hits lost to a full FIFO, saturating.
- halt  out  1  optional-feature output; tied 0 when the feature is compiled out.

Behaviour:
- Reset (reset=0 at a clock edge):
  - all outputs go to 0: res_valid, res_nonce, primed, found_count, drop_count, halt;
  - FIFO pointers and warm-up counter clear;
  - the delay-line RAM contents are not cleared;
  - a reset mid-operation discards queued results and restarts warm-up.
- Delay line:
  - circular buffer of LATENCY × 32 bits with write pointer wp (0..LATENCY-1, wraps to 0);
  - every cycle, first read mem[wp] as `delayed_nonce`, then write mem[wp] ← nonce_in and advance wp;
  - `delayed_nonce` at cycle t therefore equals nonce_in at cycle t−LATENCY.
- State machine, two base states:
  - WARMUP: a counter increments each cycle; `hit_in` is ignored. On reaching LATENCY−1, go to RUN next cycle and set primed=1.
  - RUN: a hit is `hit_in`=1 in this state.
- Hit handling, in RUN:
  - FIFO not full → push `delayed_nonce`; found_count += 1, saturating at all-ones.
  - FIFO full and no pop this cycle → discard; drop_count += 1, saturating.
  - FIFO full with a pop this cycle (res_ready=1) → the push is accepted; it counts as found, not dropped.
- Result FIFO:
  - first-word-fall-through; res_nonce = head entry;
  - push and pop in the same cycle are both honoured;
  - pop while empty has no effect;
  - res_valid updates the cycle after a push into an empty FIFO, i.e. 1-cycle latency from `hit_in` to res_valid.
- Overall latency: nonce_in at cycle t → res_valid high at t+LATENCY+1, when `hit_in` is asserted at t+LATENCY.
- Counters never wrap.

Optional Feature:
- Macro: COLLECTOR_HALT_ON_FIND_EN.
- Defined:
  - adds a third state, HALTED;
  - the first accepted push in RUN moves to HALTED, with halt=1 from the next cycle;
  - in HALTED, further `hit_in` pulses are ignored and counters do not change;
  - the FIFO still drains normally;
  - only reset leaves HALTED; halt is intended to gate the nonce generator.
- Undefined: no HALTED state; halt is tied to 0; collection is continuous.

Test Plan (LATENCY=4, FIFO_DEPTH=2, CNT_W=16):
1. Warm-up masking:
   - stimulus: release reset; nonce_in = 0,1,2,…; hit_in=1 on cycles 0–3;
   - required: no push, found_count=0; primed=1 from cycle 4.
2. Association:
   - stimulus: nonce_in=0x1000+cycle; single hit_in pulse at cycle 10; res_ready=0;
   - required: res_valid=1 at cycle 11, res_nonce=0x1006, found_count=1.
3. Overflow:
   - stimulus: res_ready=0; hits at cycles 10, 11, 12;
   - required: FIFO holds 0x1006, 0x1007; drop_count=1, found_count=2.
   - follow-up stimulus: res_ready=1 for 2 cycles;
   - required: outputs 0x1006 then 0x1007; res_valid drops afterwards.
4. Full with simultaneous push and pop:
   - stimulus: FIFO full; hit_in=1 and res_ready=1 in the same cycle;
   - required: drop_count unchanged, found_count+1, occupancy stays 2.
5. Mid-operation reset:
   - stimulus: 2 entries queued; reset=0 for 1 cycle;
   - required: res_valid=0, counters 0, primed=0; a hit within the next 4 cycles is ignored.
6. With COLLECTOR_HALT_ON_FIND_EN defined:
   - stimulus: hits at cycles 10 and 15;
   - required: halt=1 from cycle 11; only 0x1006 is queued; found_count=1, drop_count=0.

Source files
------------

// File: rtl/golden_nonce_collector.sv
// Re-associates target-checker hits with their nonces, queues winners in a FWFT FIFO,
// and keeps saturating found/dropped counters. Optional: COLLECTOR_HALT_ON_FIND_EN.
module golden_nonce_collector #(
  parameter int unsigned LATENCY    = 200,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      nonce_in,
  input  logic             hit_in,
  output logic             res_valid,
  output logic [31:0]      res_nonce,
  input  logic             res_ready,
  output logic             primed,
  output logic [CNT_W-1:0] found_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             halt
);

  localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

`ifdef COLLECTOR_HALT_ON_FIND_EN
  typedef enum logic [1:0] {ST_WARMUP, ST_RUN, ST_HALTED} state_t;
`else
  typedef enum logic [1:0] {ST_WARMUP, ST_RUN} state_t;
`endif

  state_t state, state_nxt;

  logic [31:0]      dly_mem [LATENCY];
  logic [LAT_W-1:0] wp;
  logic [31:0]      delayed_nonce;
  logic [LAT_W-1:0] warm_cnt;

  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic full;
  logic pop;
  logic hit_run;
  logic push;
  logic drop;

  // Delay line: read-before-write at wp gives the nonce issued LATENCY cycles ago.
  assign delayed_nonce = dly_mem[wp];

  always_ff @(posedge clk) begin
    dly_mem[wp] <= nonce_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
    end else if (wp == LAT_W'(LATENCY - 1)) begin
      wp <= '0;
    end else begin
      wp <= wp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      warm_cnt <= '0;
    end else if (state == ST_WARMUP) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  // Hit qualification; a full FIFO still accepts when the consumer pops this cycle.
  assign full    = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop     = res_ready && (count != '0);
  assign hit_run = (state == ST_RUN) && hit_in;
  assign push    = hit_run && (!full || pop);
  assign drop    = hit_run && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= delayed_nonce;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      found_count <= '0;
      drop_count  <= '0;
    end else begin
      if (push && (found_count != '1)) found_count <= found_count + 1'b1;
      if (drop && (drop_count != '1))  drop_count  <= drop_count + 1'b1;
    end
  end

  assign res_valid = (count != '0);
  assign res_nonce = res_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_WARMUP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WARMUP: if (warm_cnt == LAT_W'(LATENCY - 1)) state_nxt = ST_RUN;
`ifdef COLLECTOR_HALT_ON_FIND_EN
      ST_RUN:    if (push) state_nxt = ST_HALTED;
      ST_HALTED: state_nxt = ST_HALTED;
`else
      ST_RUN:    state_nxt = ST_RUN;
`endif
      default:   state_nxt = ST_WARMUP;
    endcase
  end

  always_comb begin
    primed = (state != ST_WARMUP);
`ifdef COLLECTOR_HALT_ON_FIND_EN
    halt   = (state == ST_HALTED);
`else
    halt   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_golden_nonce_collector.sv
// Bench for golden_nonce_collector (LATENCY=4, FIFO_DEPTH=2, CNT_W=16) with a queue-based reference model.
module tb_golden_nonce_collector;

  localparam int unsigned L = 4;
  localparam int unsigned D = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] nonce_in;
  logic        hit_in;
  logic        res_valid;
  logic [31:0] res_nonce;
  logic        res_ready;
  logic        primed;
  logic [15:0] found_count;
  logic [15:0] drop_count;
  logic        halt;

  golden_nonce_collector #(
    .LATENCY    (L),
    .FIFO_DEPTH (D),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .nonce_in    (nonce_in),
    .hit_in      (hit_in),
    .res_valid   (res_valid),
    .res_nonce   (res_nonce),
    .res_ready   (res_ready),
    .primed      (primed),
    .found_count (found_count),
    .drop_count  (drop_count),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: nonce history since reset release, result queue, counters.
  logic [31:0] m_hist[$];
  logic [31:0] m_q[$];
  int unsigned m_cyc;
  int unsigned m_found;
  int unsigned m_drop;
  bit          m_halted;

  function automatic logic [82:0] exp_vec();
    logic        v;
    logic [31:0] n;
    v = (m_q.size() != 0);
    n = v ? m_q[0] : 32'h0;
    return {v, n, (m_cyc >= L), m_found[15:0], m_drop[15:0], m_halted};
  endfunction

  task automatic step(input logic [31:0] n, input logic h, input logic r, input logic rs);
    bit run, do_pop, is_full;
    nonce_in  = n;
    hit_in    = h;
    res_ready = r;
    reset     = rs;
    @(posedge clk);
    if (!rs) begin
      m_hist.delete();
      m_q.delete();
      m_cyc = 0; m_found = 0; m_drop = 0; m_halted = 0;
    end else begin
      run     = (m_cyc >= L) && !m_halted;
      do_pop  = r && (m_q.size() != 0);
      is_full = (m_q.size() == D);
      if (do_pop) void'(m_q.pop_front());
      if (run && h) begin
        if (!is_full || do_pop) begin
          m_q.push_back(m_hist[m_cyc - L]);
          if (m_found < 65535) m_found++;
`ifdef COLLECTOR_HALT_ON_FIND_EN
          m_halted = 1;
`endif
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
      m_hist.push_back(n);
      m_cyc++;
    end
    #1;
  endtask

  task automatic test_reset();
    step(32'hdead_beef, 1'b1, 1'b1, 1'b0);
    step(32'h1234_5678, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({res_valid, res_nonce, primed, found_count, drop_count, halt} !== 83'h0)
      $display("FAIL reset_outputs: got v=%b n=%h p=%b f=%0d d=%0d h=%b, need all zero",
               res_valid, res_nonce, primed, found_count, drop_count, halt);
    else n_pass++;
  endtask

  task automatic test_warmup();
    step(32'h0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step(32'(c), (c < 4), 1'b0, 1'b1);
      n_checks++;
      if (primed !== (c >= 3) || found_count !== 16'd0 || res_valid !== 1'b0)
        $display("FAIL warmup_c%0d: got p=%b f=%0d v=%b, need p=%b f=0 v=0",
                 c, primed, found_count, res_valid, (c >= 3));
      else n_pass++;
      n_checks++;
      if ({res_valid, res_nonce, primed, found_count, drop_count, halt} !== exp_vec())
        $display("FAIL warmup_model_c%0d: got %h need %h", c,
                 {res_valid, res_nonce, primed, found_count, drop_count, halt}, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_association();
    step(32'h0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c <= 10; c++) begin
      step(32'h1000 + 32'(c), (c == 10), 1'b0, 1'b1);
      if (c == 9) begin
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL assoc_early: got v=%b need 0", res_valid);
        else n_pass++;
      end
    end
    n_checks++;
    if (res_valid !== 1'b1 || res_nonce !== 32'h1006 || found_count !== 16'd1)
      $display("FAIL assoc: got v=%b n=%h f=%0d, need v=1 n=00001006 f=1",
               res_valid, res_nonce, found_count);
    else n_pass++;
  endtask

  task automatic test_overflow();
    step(32'h0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c <= 12; c++)
      step(32'h1000 + 32'(c), (c >= 10), 1'b0, 1'b1);
    n_checks++;
    if (res_nonce !== 32'h1006 || drop_count !== 16'd1 || found_count !== 16'd2)
      $display("FAIL overflow_counts: got n=%h f=%0d d=%0d, need n=00001006 f=2 d=1",
               res_nonce, found_count, drop_count);
    else n_pass++;
    step(32'h100d, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (res_valid !== 1'b1 || res_nonce !== 32'h1007)
      $display("FAIL overflow_pop1: got v=%b n=%h, need v=1 n=00001007", res_valid, res_nonce);
    else n_pass++;
    step(32'h100e, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (res_valid !== 1'b0)
      $display("FAIL overflow_pop2: got v=%b need 0", res_valid);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    step(32'h0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c <= 11; c++)
      step(32'h1000 + 32'(c), (c >= 10), 1'b0, 1'b1);
`ifndef COLLECTOR_HALT_ON_FIND_EN
    step(32'h100c, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (drop_count !== 16'd0 || found_count !== 16'd3 || res_valid !== 1'b1 || res_nonce !== 32'h1007)
      $display("FAIL full_push_pop: got f=%0d d=%0d v=%b n=%h, need f=3 d=0 v=1 n=00001007",
               found_count, drop_count, res_valid, res_nonce);
    else n_pass++;
    step(32'h100d, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (res_valid !== 1'b1 || res_nonce !== 32'h1008)
      $display("FAIL full_push_pop_drain1: got v=%b n=%h, need v=1 n=00001008", res_valid, res_nonce);
    else n_pass++;
    step(32'h100e, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (res_valid !== 1'b0)
      $display("FAIL full_push_pop_drain2: got v=%b need 0", res_valid);
    else n_pass++;
`endif
  endtask

  task automatic test_mid_reset();
    step(32'h0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c <= 11; c++)
      step(32'h2000 + 32'(c), (c >= 10), 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (res_valid !== 1'b0 || found_count !== 16'd0 || drop_count !== 16'd0 || primed !== 1'b0 || halt !== 1'b0)
      $display("FAIL mid_reset: got v=%b f=%0d d=%0d p=%b h=%b, need all 0",
               res_valid, found_count, drop_count, primed, halt);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      step(32'h3000 + 32'(c), 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (res_valid !== 1'b0 || found_count !== 16'd0)
        $display("FAIL mid_reset_warm_c%0d: got v=%b f=%0d, need v=0 f=0", c, res_valid, found_count);
      else n_pass++;
    end
  endtask

`ifdef COLLECTOR_HALT_ON_FIND_EN
  task automatic test_halt();
    step(32'h0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c <= 16; c++) begin
      step(32'h1000 + 32'(c), (c == 10 || c == 15), 1'b0, 1'b1);
      if (c == 9 || c == 10) begin
        n_checks++;
        if (halt !== (c == 10)) $display("FAIL halt_c%0d: got %b need %b", c, halt, (c == 10));
        else n_pass++;
      end
    end
    n_checks++;
    if (found_count !== 16'd1 || drop_count !== 16'd0 || res_nonce !== 32'h1006 || halt !== 1'b1)
      $display("FAIL halt_final: got f=%0d d=%0d n=%h h=%b, need f=1 d=0 n=00001006 h=1",
               found_count, drop_count, res_nonce, halt);
    else n_pass++;
    step(32'h0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL halt_single_entry: got v=%b need 0", res_valid);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    bit rs;
    step(32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(99, 0) != 0);
      step($urandom, ($urandom_range(99, 0) < 60), ($urandom_range(99, 0) < 40), rs);
      n_checks++;
      if ({res_valid, res_nonce, primed, found_count, drop_count, halt} !== exp_vec())
        $display("FAIL random_i%0d: got v=%b n=%h p=%b f=%0d d=%0d h=%b, need %h",
                 i, res_valid, res_nonce, primed, found_count, drop_count, halt, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b0; nonce_in = '0; hit_in = 1'b0; res_ready = 1'b0;
    m_cyc = 0; m_found = 0; m_drop = 0; m_halted = 0;
    test_reset();
    test_warmup();
    test_association();
    test_overflow();
    test_full_push_pop();
    test_mid_reset();
`ifdef COLLECTOR_HALT_ON_FIND_EN
    test_halt();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
